idex_hazard_stage: RTL and testbench
====================================

Name: idex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core.
- Captures decoded ID-stage fields each cycle and presents the IDEX_* register fields and s_or_b to the forwarding unit and EX stage.
- Inserts bubbles on branch flush and on load-use hazards, raises STALL to freeze PC and IF/ID, and freezes itself on data-memory stall.
- Keeps a saturating count of load-use bubbles.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_VALID  in  1  ID stage holds a real instruction.
- ID_OPCODE  in  7  instruction[6:0].
- ID_RS1, ID_RS2, ID_RD  in  5 each  register indices.
- ID_RS1_DATA, ID_RS2_DATA, ID_IMM, ID_PC  in  XLEN each  operands.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc  in  1 each  decoded controls.
- ID_ALU_CTRL  in  4  ALU operation.
- FLUSH  in  1  branch/jump resolved taken in EX; kill ID.
- MEM_STALL  in  1  data memory busy; hold the whole pipe.
- IDEX_VALID, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc  out  1 each  registered.
- IDEX_RS, IDEX_RT, IDEX_RD  out  5 each  registered rs1/rs2/rd.
- IDEX_RS1_DATA, IDEX_RS2_DATA, IDEX_IMM, IDEX_PC  out  XLEN each  registered.
- IDEX_ALU_CTRL  out  4  registered.
- s_or_b  out  1  registered; the EX instruction is S-type (0100011) or B-type (1100011).
- STALL  out  1  combinational; hold PC and IF/ID.
- BUBBLE_CNT  out  CNT_W  count of load-use bubbles.

Behaviour:
- Reset: all registered outputs are 0 and BUBBLE_CNT is 0. Reset overrides every other input.
- uses_rs1 is 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111); it is 1 otherwise.
- uses_rs2 is 1 for R-type (0110011), S-type and B-type; it is 0 otherwise.
- hazard = ID_VALID & IDEX_VALID & IDEX_MemRead & (IDEX_RD != 0) & ((uses_rs1 & IDEX_RD == ID_RS1) | (uses_rs2 & IDEX_RD == ID_RS2)).
- STALL = MEM_STALL | (hazard & ~FLUSH).
- Per-edge priority, highest first:
  1. rst: clear everything.
  2. MEM_STALL: hold all registers and the counter unchanged, even if FLUSH or hazard is asserted.
  3. FLUSH: load a bubble.
  4. hazard: load a bubble and increment BUBBLE_CNT.
  5. Otherwise: load the ID fields. IDEX_VALID = ID_VALID. s_or_b is decoded from ID_OPCODE and gated by ID_VALID.
- Bubble: every IDEX_* output and s_or_b are 0. IDEX_RD = 0, so no forwarding or writeback occurs.
- An ID_VALID = 0 load behaves as a bubble for all controls (RegWrite, MemRead, MemWrite, s_or_b = 0). Data fields are still captured.
- Latency: one cycle from ID inputs to IDEX_* outputs.
- Load-use costs exactly one bubble. On the next cycle IDEX_MemRead = 0, so hazard drops and the held instruction enters.
- BUBBLE_CNT saturates at all-ones and does not wrap. It counts only hazard bubbles, not flush bubbles and not MEM_STALL cycles.
- FLUSH and hazard together: a flush bubble is loaded, STALL = 0 and the counter is unchanged.
- Hazard against x0 never stalls. Hazard requires IDEX_VALID.
- Reset asserted during MEM_STALL or during a stall still clears all state on that edge.

Test Plan:
- Reset: rst = 1 for 2 cycles with arbitrary inputs -> all outputs 0, BUBBLE_CNT = 0, STALL = MEM_STALL.
- Load-use: lw x5 in EX, add x6,x5,x1 in ID -> STALL = 1 for 1 cycle. Next cycle IDEX_VALID = 0 and BUBBLE_CNT = 1. The cycle after, IDEX_RS = 5 and IDEX_RD = 6.
- No false stall:
  - lw x0 followed by use of x0 -> STALL = 0.
  - lw x5 followed by lui x5 -> STALL = 0.
  - lw x5 followed by addi x7,x6,imm with ID_RS2 = 5 -> STALL = 0.
- Flush priority: FLUSH = 1 while a hazard is present -> STALL = 0, a bubble is loaded, BUBBLE_CNT unchanged.
- MEM_STALL hold: sw x3,0(x4) in ID, then MEM_STALL = 1 for 3 cycles -> registers frozen and STALL = 1. After release, s_or_b = 1, IDEX_RS = 4, IDEX_RT = 3.
- Saturation: CNT_W = 2, force 5 hazards -> BUBBLE_CNT sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core, with load-use hazard
// detection, flush/stall bubble insertion and a saturating load-use bubble counter.
module idex_hazard_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_VALID,
  input  logic [6:0]       ID_OPCODE,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic [4:0]       ID_RD,
  input  logic [XLEN-1:0]  ID_RS1_DATA,
  input  logic [XLEN-1:0]  ID_RS2_DATA,
  input  logic [XLEN-1:0]  ID_IMM,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic             ID_ALUSrc,
  input  logic [3:0]       ID_ALU_CTRL,
  input  logic             FLUSH,
  input  logic             MEM_STALL,
  output logic             IDEX_VALID,
  output logic             IDEX_RegWrite,
  output logic             IDEX_MemRead,
  output logic             IDEX_MemWrite,
  output logic             IDEX_ALUSrc,
  output logic [4:0]       IDEX_RS,
  output logic [4:0]       IDEX_RT,
  output logic [4:0]       IDEX_RD,
  output logic [XLEN-1:0]  IDEX_RS1_DATA,
  output logic [XLEN-1:0]  IDEX_RS2_DATA,
  output logic [XLEN-1:0]  IDEX_IMM,
  output logic [XLEN-1:0]  IDEX_PC,
  output logic [3:0]       IDEX_ALU_CTRL,
  output logic             s_or_b,
  output logic             STALL,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            s_or_b;
    logic [3:0]      alu_ctrl;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } idex_t;

  idex_t            idex_q;
  idex_t            id_img;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             hazard;
  logic             load_use_bubble;
  logic [CNT_W-1:0] bubble_cnt_q;

  assign uses_rs1 = !(ID_OPCODE == OP_LUI || ID_OPCODE == OP_AUIPC || ID_OPCODE == OP_JAL);
  assign uses_rs2 = (ID_OPCODE == OP_RTYPE || ID_OPCODE == OP_STORE || ID_OPCODE == OP_BRANCH);

  assign hazard = ID_VALID && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  ((uses_rs1 && idex_q.rd == ID_RS1) || (uses_rs2 && idex_q.rd == ID_RS2));

  // A taken branch kills the dependent instruction, so the stall would be wasted.
  assign load_use_bubble = hazard && !FLUSH;
  assign STALL           = MEM_STALL || load_use_bubble;

  // NOTE: every field gets a default first so this block can never infer a latch.
  always_comb begin
    id_img           = '0;
    id_img.valid     = ID_VALID;
    id_img.reg_write = ID_VALID && ID_RegWrite;
    id_img.mem_read  = ID_VALID && ID_MemRead;
    id_img.mem_write = ID_VALID && ID_MemWrite;
    id_img.alu_src   = ID_ALUSrc;
    id_img.s_or_b    = ID_VALID && (ID_OPCODE == OP_STORE || ID_OPCODE == OP_BRANCH);
    id_img.alu_ctrl  = ID_ALU_CTRL;
    id_img.rs        = ID_RS1;
    id_img.rt        = ID_RS2;
    id_img.rd        = ID_RD;
    id_img.rs1_data  = ID_RS1_DATA;
    id_img.rs2_data  = ID_RS2_DATA;
    id_img.imm       = ID_IMM;
    id_img.pc        = ID_PC;
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and wins over hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else if (!MEM_STALL) begin
      if (FLUSH || hazard) idex_q <= '0;
      else                 idex_q <= id_img;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (!MEM_STALL && load_use_bubble && bubble_cnt_q != '1) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign IDEX_VALID    = idex_q.valid;
  assign IDEX_RegWrite = idex_q.reg_write;
  assign IDEX_MemRead  = idex_q.mem_read;
  assign IDEX_MemWrite = idex_q.mem_write;
  assign IDEX_ALUSrc   = idex_q.alu_src;
  assign IDEX_RS       = idex_q.rs;
  assign IDEX_RT       = idex_q.rt;
  assign IDEX_RD       = idex_q.rd;
  assign IDEX_RS1_DATA = idex_q.rs1_data;
  assign IDEX_RS2_DATA = idex_q.rs2_data;
  assign IDEX_IMM      = idex_q.imm;
  assign IDEX_PC       = idex_q.pc;
  assign IDEX_ALU_CTRL = idex_q.alu_ctrl;
  assign s_or_b        = idex_q.s_or_b;
  assign BUBBLE_CNT    = bubble_cnt_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench for idex_hazard_stage: directed vectors push hand-derived
// expectations; a monitor checks STALL before each edge and the registers after it.
module tb_idex_hazard_stage;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, as;
    logic [3:0]  alu;
    logic [31:0] d1, d2, imm, pc;
  } instr_t;

  typedef struct {
    string       name;
    logic        stall;
    instr_t      img;
    logic        sb;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_rw, id_mr, id_mw, id_as, flush, mem_stall;
  logic [6:0]  id_op;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_d1, id_d2, id_imm, id_pc;
  logic [3:0]  id_alu;

  logic        q_valid, q_rw, q_mr, q_mw, q_as, q_sb, stall;
  logic [4:0]  q_rs, q_rt, q_rd;
  logic [31:0] q_d1, q_d2, q_imm, q_pc;
  logic [3:0]  q_alu;
  logic [15:0] cnt16;

  logic        s_valid, s_rw, s_mr, s_mw, s_as, s_sb, s_stall;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_d1, s_d2, s_imm, s_pc;
  logic [3:0]  s_alu;
  logic [1:0]  cnt2;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  idex_hazard_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_VALID(id_valid), .ID_OPCODE(id_op),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_RD(id_rd),
    .ID_RS1_DATA(id_d1), .ID_RS2_DATA(id_d2), .ID_IMM(id_imm), .ID_PC(id_pc),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw), .ID_ALUSrc(id_as),
    .ID_ALU_CTRL(id_alu), .FLUSH(flush), .MEM_STALL(mem_stall),
    .IDEX_VALID(q_valid), .IDEX_RegWrite(q_rw), .IDEX_MemRead(q_mr),
    .IDEX_MemWrite(q_mw), .IDEX_ALUSrc(q_as),
    .IDEX_RS(q_rs), .IDEX_RT(q_rt), .IDEX_RD(q_rd),
    .IDEX_RS1_DATA(q_d1), .IDEX_RS2_DATA(q_d2), .IDEX_IMM(q_imm), .IDEX_PC(q_pc),
    .IDEX_ALU_CTRL(q_alu), .s_or_b(q_sb), .STALL(stall), .BUBBLE_CNT(cnt16)
  );

  idex_hazard_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ID_VALID(id_valid), .ID_OPCODE(id_op),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_RD(id_rd),
    .ID_RS1_DATA(id_d1), .ID_RS2_DATA(id_d2), .ID_IMM(id_imm), .ID_PC(id_pc),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw), .ID_ALUSrc(id_as),
    .ID_ALU_CTRL(id_alu), .FLUSH(flush), .MEM_STALL(mem_stall),
    .IDEX_VALID(s_valid), .IDEX_RegWrite(s_rw), .IDEX_MemRead(s_mr),
    .IDEX_MemWrite(s_mw), .IDEX_ALUSrc(s_as),
    .IDEX_RS(s_rs), .IDEX_RT(s_rt), .IDEX_RD(s_rd),
    .IDEX_RS1_DATA(s_d1), .IDEX_RS2_DATA(s_d2), .IDEX_IMM(s_imm), .IDEX_PC(s_pc),
    .IDEX_ALU_CTRL(s_alu), .s_or_b(s_sb), .STALL(s_stall), .BUBBLE_CNT(cnt2)
  );

  function automatic instr_t mk(input bit v, input logic [6:0] op, input int rs1, input int rs2,
                                input int rd, input bit rw, input bit mr, input bit mw,
                                input bit as, input logic [3:0] alu, input logic [31:0] tag);
    instr_t i;
    i.valid = v;  i.op = op;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
    i.rw = rw; i.mr = mr; i.mw = mw; i.as = as; i.alu = alu;
    i.d1 = tag + 32'h1; i.d2 = tag + 32'h2; i.imm = tag + 32'h3; i.pc = tag;
    return i;
  endfunction

  // Image expected in ID/EX after loading an ID_VALID=0 instruction.
  function automatic instr_t gated(input instr_t i);
    instr_t g = i;
    g.valid = 1'b0; g.rw = 1'b0; g.mr = 1'b0; g.mw = 1'b0;
    return g;
  endfunction

  task automatic check(input string name, input string what, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", name, what, act, req);
    end
  endtask

  task automatic step(input string name, input instr_t id, input bit fl, input bit ms,
                      input bit r, input bit x_stall, input instr_t x_img, input bit x_sb,
                      input int x_c16, input int x_c2);
    exp_t e;
    @(negedge clk);
    rst = r; flush = fl; mem_stall = ms;
    id_valid = id.valid; id_op = id.op;
    id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
    id_rw = id.rw; id_mr = id.mr; id_mw = id.mw; id_as = id.as; id_alu = id.alu;
    id_d1 = id.d1; id_d2 = id.d2; id_imm = id.imm; id_pc = id.pc;
    e.name = name; e.stall = x_stall; e.img = x_img; e.sb = x_sb;
    e.c16 = 16'(x_c16); e.c2 = 2'(x_c2);
    q.push_back(e);
  endtask

  // Monitor: STALL is combinational so it is sampled before the edge it governs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q[0];
        check(e.name, "stall", 64'(stall), 64'(e.stall));
        @(posedge clk);
        #1;
        check(e.name, "ctrl", 64'({q_valid, q_rw, q_mr, q_mw, q_as, q_sb, q_alu}),
              64'({e.img.valid, e.img.rw, e.img.mr, e.img.mw, e.img.as, e.sb, e.img.alu}));
        check(e.name, "regs", 64'({q_rs, q_rt, q_rd}), 64'({e.img.rs1, e.img.rs2, e.img.rd}));
        check(e.name, "rs1_data", 64'(q_d1), 64'(e.img.d1));
        check(e.name, "rs2_data", 64'(q_d2), 64'(e.img.d2));
        check(e.name, "imm", 64'(q_imm), 64'(e.img.imm));
        check(e.name, "pc", 64'(q_pc), 64'(e.img.pc));
        check(e.name, "bubble_cnt", 64'(cnt16), 64'(e.c16));
        check(e.name, "bubble_cnt_sat", 64'(cnt2), 64'(e.c2));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached with %0d pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t nop, lw5, add6, lw0, add8, lui5, addi7, or10, sw, beq;
    instr_t inv_sw, add6_inv, add_rs2, sw5, beq5;
    nop      = mk(0, 7'd0,   0,  0,  0, 0, 0, 0, 0, 4'h0, 32'h0);
    nop.d1 = '0; nop.d2 = '0; nop.imm = '0;
    lw5      = mk(1, OP_LW,  2,  0,  5, 1, 1, 0, 1, 4'h0, 32'h100);
    add6     = mk(1, OP_R,   5,  1,  6, 1, 0, 0, 0, 4'h0, 32'h200);
    lw0      = mk(1, OP_LW,  3,  0,  0, 1, 1, 0, 1, 4'h0, 32'h300);
    add8     = mk(1, OP_R,   0,  0,  8, 1, 0, 0, 0, 4'h0, 32'h400);
    lui5     = mk(1, OP_LUI, 5,  0,  5, 1, 0, 0, 1, 4'hA, 32'h500);
    addi7    = mk(1, OP_I,   6,  5,  7, 1, 0, 0, 1, 4'h0, 32'h600);
    or10     = mk(1, OP_R,  11, 12, 10, 1, 0, 0, 0, 4'h3, 32'h700);
    sw       = mk(1, OP_S,   4,  3,  0, 0, 0, 1, 1, 4'h0, 32'h800);
    beq      = mk(1, OP_B,   1,  2,  0, 0, 0, 0, 0, 4'h1, 32'h900);
    inv_sw   = mk(0, OP_S,   4,  5,  9, 1, 1, 1, 0, 4'h0, 32'hA00);
    add6_inv = mk(0, OP_R,   5,  1,  6, 1, 0, 0, 0, 4'h0, 32'hB00);
    add_rs2  = mk(1, OP_R,   1,  5,  6, 1, 0, 0, 0, 4'h0, 32'hC00);
    sw5      = mk(1, OP_S,   4,  5,  0, 0, 0, 1, 1, 4'h0, 32'hD00);
    beq5     = mk(1, OP_B,   5,  7,  0, 0, 0, 0, 0, 4'h1, 32'hE00);

    //    name            id        fl ms r  stall image     sb c16 c2
    step("reset1",        add6,     1, 1, 1, 1, nop,      0, 0, 0);
    step("reset2",        lw5,      0, 0, 1, 0, nop,      0, 0, 0);
    step("lw_x5",         lw5,      0, 0, 0, 0, lw5,      0, 0, 0);
    step("load_use",      add6,     0, 0, 0, 1, nop,      0, 1, 1);
    step("use_enters",    add6,     0, 0, 0, 0, add6,     0, 1, 1);
    step("lw_x0",         lw0,      0, 0, 0, 0, lw0,      0, 1, 1);
    step("use_x0",        add8,     0, 0, 0, 0, add8,     0, 1, 1);
    step("lw_x5_b",       lw5,      0, 0, 0, 0, lw5,      0, 1, 1);
    step("lui_x5",        lui5,     0, 0, 0, 0, lui5,     0, 1, 1);
    step("lw_x5_c",       lw5,      0, 0, 0, 0, lw5,      0, 1, 1);
    step("addi_rs2_x5",   addi7,    0, 0, 0, 0, addi7,    0, 1, 1);
    step("lw_x5_d",       lw5,      0, 0, 0, 0, lw5,      0, 1, 1);
    step("flush_hazard",  add6,     1, 0, 0, 0, nop,      0, 1, 1);
    step("or_x10",        or10,     0, 0, 0, 0, or10,     0, 1, 1);
    step("mstall1",       sw,       0, 1, 0, 1, or10,     0, 1, 1);
    step("mstall2_flush", sw,       1, 1, 0, 1, or10,     0, 1, 1);
    step("mstall3",       sw,       0, 1, 0, 1, or10,     0, 1, 1);
    step("sw_enters",     sw,       0, 0, 0, 0, sw,       1, 1, 1);
    step("beq",           beq,      0, 0, 0, 0, beq,      1, 1, 1);
    step("lw_x5_e",       lw5,      0, 0, 0, 0, lw5,      0, 1, 1);
    step("mstall_hazard", add6,     0, 1, 0, 1, lw5,      0, 1, 1);
    step("hazard_after",  add6,     0, 0, 0, 1, nop,      0, 2, 2);
    step("use_enters_b",  add6,     0, 0, 0, 0, add6,     0, 2, 2);
    step("invalid_sw",    inv_sw,   0, 0, 0, 0, gated(inv_sw), 0, 2, 2);
    step("lw_x5_f",       lw5,      0, 0, 0, 0, lw5,      0, 2, 2);
    step("invalid_use",   add6_inv, 0, 0, 0, 0, gated(add6_inv), 0, 2, 2);
    step("lw_x5_g",       lw5,      0, 0, 0, 0, lw5,      0, 2, 2);
    step("hazard_rs2",    add_rs2,  0, 0, 0, 1, nop,      0, 3, 3);
    step("add_rs2_in",    add_rs2,  0, 0, 0, 0, add_rs2,  0, 3, 3);
    step("lw_x5_h",       lw5,      0, 0, 0, 0, lw5,      0, 3, 3);
    step("hazard_sw",     sw5,      0, 0, 0, 1, nop,      0, 4, 3);
    step("sw5_in",        sw5,      0, 0, 0, 0, sw5,      1, 4, 3);
    step("lw_x5_i",       lw5,      0, 0, 0, 0, lw5,      0, 4, 3);
    step("hazard_beq",    beq5,     0, 0, 0, 1, nop,      0, 5, 3);
    step("beq5_in",       beq5,     0, 0, 0, 0, beq5,     1, 5, 3);
    step("lw_x5_j",       lw5,      0, 0, 0, 0, lw5,      0, 5, 3);
    step("reset_in_stall", add6,    0, 0, 1, 1, nop,      0, 0, 0);
    step("after_reset",   add6,     0, 0, 0, 0, add6,     0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
